// File: rtl/conv_rsc_frame_enc.sv
// Framed RSC convolutional encoder: word in, serial MSB-first encode, systematic/parity words out.
// Define CONV_RSC_TAIL_EN to terminate each frame to the zero state and emit tail bits on a final beat.
module conv_rsc_frame_enc #(
    parameter int            DW          = 4,
    parameter int            K           = 3,
    parameter logic [K-1:0]  G0          = 3'b111,
    parameter logic [K-1:0]  G1          = 3'b101,
    parameter int            FRAME_WORDS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DW-1:0]        out_sys,
    output logic [DW-1:0]        out_par,
    output logic [2*(K-1)-1:0]   out_tail,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SW  = K - 1;
    localparam int CW  = $clog2((DW > K ? DW : K) + 1);
    localparam int WCW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        OUT,
`ifdef CONV_RSC_TAIL_EN
        TAIL,
        TOUT,
`endif
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q;
    logic [DW-1:0]   sh_q;
    logic [CW-1:0]   bit_cnt;
    logic [WCW-1:0]  word_cnt;
    logic            fb, tap, u, a, p;
    logic            bit_last, frame_end, out_fire;

    assign out_fire  = out_valid && out_ready;
    assign frame_end = (word_cnt == WCW'(FRAME_WORDS - 1));
    assign bit_last  = (state_q == SHIFT) ? (bit_cnt == CW'(DW - 1)) : (bit_cnt == CW'(K - 2));

    // Tap i of a polynomial (i < K-1) lines up with s[K-2-i]; the top tap lines up with a.
    // In the tail the input bit equals the feedback, which forces a to zero.
    always_comb begin
        fb  = 1'b0;
        tap = 1'b0;
        for (int i = 0; i < SW; i++) begin
            fb  = fb  ^ (G0[i] & s_q[SW-1-i]);
            tap = tap ^ (G1[i] & s_q[SW-1-i]);
        end
        u = (state_q == SHIFT) ? sh_q[DW-1] : fb;
        a = u ^ fb;
        p = tap ^ (G1[K-1] & a);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (in_valid && in_ready) state_d = SHIFT;
            SHIFT: if (bit_last) state_d = OUT;
            OUT: begin
                if (out_fire) begin
`ifdef CONV_RSC_TAIL_EN
                    state_d = frame_end ? TAIL : IDLE;
`else
                    state_d = frame_end ? FIN : IDLE;
`endif
                end
            end
`ifdef CONV_RSC_TAIL_EN
            TAIL:  if (bit_last) state_d = TOUT;
            TOUT:  if (out_fire) state_d = FIN;
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The word register rotates rather than shifts, so after DW bits it holds the original word again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sys   <= '0;
            out_par   <= '0;
            out_last  <= 1'b0;
            s_q       <= '0;
            sh_q      <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            in_ready <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sh_q    <= in_data;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    s_q     <= {s_q[SW-2:0], a};
                    sh_q    <= {sh_q[DW-2:0], sh_q[DW-1]};
                    out_par <= {out_par[DW-2:0], p};
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_last) begin
                        out_valid <= 1'b1;
                        out_sys   <= {sh_q[DW-2:0], sh_q[DW-1]};
                        bit_cnt   <= '0;
`ifndef CONV_RSC_TAIL_EN
                        out_last  <= frame_end;
`endif
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        word_cnt  <= word_cnt + WCW'(1);
                    end
                end
`ifdef CONV_RSC_TAIL_EN
                TAIL: begin
                    s_q     <= {s_q[SW-2:0], a};
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_last) begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_sys   <= '0;
                        out_par   <= '0;
                        bit_cnt   <= '0;
                    end
                end
                TOUT: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
`endif
                FIN: begin
                    s_q      <= '0;
                    word_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_RSC_TAIL_EN
    logic [2*SW-1:0] tail_sr;

    // Tail pairs enter at the LSB end so the first (u,p) pair ends up in the top bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tail_sr  <= '0;
            out_tail <= '0;
        end else if (state_q == TAIL) begin
            tail_sr <= {tail_sr[2*SW-3:0], u, p};
            if (bit_last) out_tail <= {tail_sr[2*SW-3:0], u, p};
        end else if (state_q == TOUT && out_fire) begin
            out_tail <= '0;
        end
    end
`else
    assign out_tail = '0;
`endif

endmodule
